// File: rtl/cache_pkg.sv
// cache_pkg: FSM state encodings, default cache geometry and clog2 shared by sram_cache_ctrl.
package cache_pkg;
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam int SRAM_AW_DEF = 18;
  localparam int LINE_WORDS_DEF = 2;
  localparam int SETS_DEF = 64;
  localparam int WAYS_DEF = 2;
  localparam int SRAM_WAIT_DEF = 1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sram_cache_ctrl_if.sv
// sram_cache_ctrl_if: MEM-stage load/store request bus with the ready stall handshake.
interface sram_cache_ctrl_if;
  logic mem_r_en, mem_w_en, ready;
  logic [31:0] address, writedata, readdata;
  modport master (output mem_r_en, mem_w_en, address, writedata, input readdata, ready);
  modport slave (input mem_r_en, mem_w_en, address, writedata, output readdata, ready);
endinterface

// File: rtl/cache_set_array.sv
// cache_set_array: tag/valid/data/LRU storage with combinational lookup and sync line/word writes.
module cache_set_array #(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  parameter int IW = 6,
  parameter int OW = 1,
  parameter int TW = 10,
  parameter int LW = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic [IW-1:0] idx_i,
  input  logic [TW-1:0] tag_i,
  output logic hit_o,
  output logic [LW-1:0] line_o,
  input  logic lw_en_i,
  input  logic [LW-1:0] lw_data_i,
  input  logic ww_en_i,
  input  logic [OW-1:0] ww_off_i,
  input  logic [31:0] ww_data_i,
  input  logic touch_i
);
  logic [TW-1:0] tag_q [WAYS][SETS];
  logic [LW-1:0] data_q [WAYS][SETS];
  logic valid_q [WAYS][SETS];
  logic lru_q [SETS];
  logic hit_way, vic_way;
  always_comb begin
    hit_o = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[w][idx_i] && tag_q[w][idx_i] == tag_i) begin
        hit_o = 1'b1;
        hit_way = 1'(w);
      end
  end
  assign line_o = data_q[hit_way][idx_i];
  // an empty way always wins over the LRU choice
  if (WAYS == 1) begin : g_dm
    assign vic_way = 1'b0;
  end else begin : g_lru
    assign vic_way = !valid_q[0][idx_i] ? 1'b0 : !valid_q[1][idx_i] ? 1'b1 : lru_q[idx_i];
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          valid_q[w][s] <= 1'b0;
      for (int s = 0; s < SETS; s++)
        lru_q[s] <= 1'b0;
    end else begin
      if (lw_en_i) begin
        valid_q[vic_way][idx_i] <= 1'b1;
        lru_q[idx_i] <= ~vic_way;
      end
      if (touch_i)
        lru_q[idx_i] <= ~hit_way;
    end
  always_ff @(posedge clk) begin
    if (lw_en_i) begin
      tag_q[vic_way][idx_i] <= tag_i;
      data_q[vic_way][idx_i] <= lw_data_i;
    end
    if (ww_en_i)
      data_q[hit_way][idx_i][ww_off_i*32 +: 32] <= ww_data_i;
  end
endmodule

// File: rtl/sram_cache_ctrl.sv
// sram_cache_ctrl: write-through, no-write-allocate read cache in front of a 16-bit SRAM.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module sram_cache_ctrl
  import cache_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int SETS = SETS_DEF,
  parameter int WAYS = WAYS_DEF,
  parameter int SRAM_WAIT = SRAM_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  sram_cache_ctrl_if.slave bus,
  output logic [SRAM_AW-1:0] SRAMaddress,
  output logic SRAMWEn,
  output logic SRAMOE,
  inout  wire  [15:0] SRAMdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OW = clog2(LINE_WORDS);
  localparam int IW = clog2(SETS);
  localparam int OWW = OW > 0 ? OW : 1;
  localparam int IWW = IW > 0 ? IW : 1;
  localparam int TW = SRAM_AW - 1 - OW - IW;
  localparam int HW = clog2(2 * LINE_WORDS);
  localparam int LW = 32 * LINE_WORDS;
  logic [1:0] state_q, state_d;
  logic [HW-1:0] hw_q, hw_d;
  logic [3:0] wc_q, wc_d;
  logic [LW-1:0] buf_q, buf_d, hit_line;
  logic fill_q, fill_d;
  logic [29:0] a, fa;
  logic [OWW-1:0] off;
  logic [IWW-1:0] idx;
  logic [TW-1:0] tag;
  logic rd, wr, hit, smp, fin, lw_en, ww_en, touch;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.address[1:0]};
  assign a = bus.address[31:2];
  assign off = OWW'(a % LINE_WORDS);
  assign idx = IWW'(a / LINE_WORDS % SETS);
  assign tag = TW'(a >> (OW + IW));
  // reset masks the request so the cycle after an abort reports idle
  assign wr = bus.mem_w_en & ~rst;
  assign rd = bus.mem_r_en & ~bus.mem_w_en & ~rst;
  assign smp = wc_q == 4'(SRAM_WAIT);
  assign fin = wc_q == 4'(SRAM_WAIT + 1);
  assign touch = state_q == IDLE && rd && hit;
  assign fa = (a & ~30'(LINE_WORDS - 1)) | 30'(hw_q >> 1);
  assign SRAMaddress = state_q == FILL ? SRAM_AW'({fa, hw_q[0]}) : SRAM_AW'({a, hw_q[0]});
  assign SRAMOE = state_q != FILL;
  assign SRAMWEn = !(state_q == WRITE && wc_q <= 4'(SRAM_WAIT));
  assign SRAMdata = state_q == WRITE ? (hw_q[0] ? bus.writedata[31:16] : bus.writedata[15:0]) : 16'hzzzz;
  assign bus.ready = state_q == DONE || (state_q == IDLE && !wr && !(rd && !hit));
  assign bus.readdata = (state_q == DONE && fill_q) ? buf_q[off*32 +: 32] :
                        touch ? hit_line[off*32 +: 32] : 32'h0;
  always_comb begin
    buf_d = buf_q;
    buf_d[hw_q*16 +: 16] = SRAMdata;
  end
  always_comb begin
    state_d = state_q;
    hw_d = hw_q;
    wc_d = wc_q;
    fill_d = fill_q;
    lw_en = 1'b0;
    ww_en = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = wr ? WRITE : (rd && !hit) ? FILL : IDLE;
        fill_d = wr ? 1'b0 : (rd && !hit) ? 1'b1 : fill_q;
      end
      FILL: begin
        wc_d = smp ? 4'd0 : wc_q + 4'd1;
        hw_d = smp ? hw_q + HW'(1) : hw_q;
        lw_en = smp && hw_q == HW'(2 * LINE_WORDS - 1);
        state_d = lw_en ? DONE : FILL;
      end
      WRITE: begin
        wc_d = fin ? 4'd0 : wc_q + 4'd1;
        hw_d = fin ? (hw_q[0] ? HW'(0) : HW'(1)) : hw_q;
        ww_en = fin && hw_q[0] && hit;
        state_d = (fin && hw_q[0]) ? DONE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      hw_q <= '0;
      wc_q <= '0;
      fill_q <= 1'b0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      hw_q <= hw_d;
      wc_q <= wc_d;
      fill_q <= fill_d;
      if (state_q == FILL && smp) buf_q <= buf_d;
    end
  cache_set_array #(
    .WAYS(WAYS), .SETS(SETS), .IW(IWW), .OW(OWW), .TW(TW), .LW(LW)
  ) u_arr (
    .clk(clk),
    .rst(rst),
    .idx_i(idx),
    .tag_i(tag),
    .hit_o(hit),
    .line_o(hit_line),
    .lw_en_i(lw_en),
    .lw_data_i(buf_d),
    .ww_en_i(ww_en),
    .ww_off_i(off),
    .ww_data_i(bus.writedata),
    .touch_i(touch)
  );
`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk)
    if (rst) begin
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      if (touch && !(&hit_q)) hit_q <= hit_q + 32'd1;
      if (state_q == DONE && fill_q && !(&miss_q)) miss_q <= miss_q + 32'd1;
    end
  assign hit_count = hit_q;
  assign miss_count = miss_q;
`endif
endmodule
